// File: rtl/riscv_core_mem_arb_pkg.sv
// rtl/riscv_core_mem_arb_pkg.sv - shared types and requester ids for the memory arbiter
package riscv_core_mem_arb_pkg;

    // Arbiter sequencing: one downstream transaction outstanding at a time
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_BUSY = 2'd1,
        WR_BUSY = 2'd2
    } arb_state_t;

    // Requester identity; also the bit position in request/grant vectors
    typedef logic [1:0] owner_t;

    localparam owner_t IC_RD = 2'd0;
    localparam owner_t DC_RD = 2'd1;
    localparam owner_t DC_WR = 2'd2;

    localparam int NUM_REQ = 3;

    // Successor in round-robin order, wrapping DC_WR back to IC_RD
    function automatic owner_t next_owner(input owner_t id);
        return (id == DC_WR) ? IC_RD : owner_t'(id + 2'd1);
    endfunction

endpackage

// File: rtl/riscv_core_rr_arbiter3.sv
// rtl/riscv_core_rr_arbiter3.sv - three-way round-robin pick with registered pointer
module riscv_core_rr_arbiter3
    import riscv_core_mem_arb_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [2:0]   i_req,
    input  logic         i_grant_en,
    output logic [2:0]   o_grant,
    output owner_t       o_grant_id,
    output logic         o_grant_valid
);

    owner_t ptr;

    // Scan requests starting at the pointer, first active one wins
    always_comb begin
        owner_t idx;
        o_grant       = 3'b000;
        o_grant_id    = ptr;
        o_grant_valid = 1'b0;
        idx           = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!o_grant_valid && i_req[idx]) begin
                o_grant_valid = 1'b1;
                o_grant_id    = idx;
                o_grant[idx]  = 1'b1;
            end
            idx = next_owner(idx);
        end
    end

    // Pointer moves past the winner only when a grant is actually taken
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr <= IC_RD;
        end else if (i_grant_en && o_grant_valid) begin
            ptr <= next_owner(o_grant_id);
        end
    end

endmodule

// File: rtl/riscv_core_mem_arbiter.sv
// rtl/riscv_core_mem_arbiter.sv - shares the external memory port between icache and dcache
module riscv_core_mem_arbiter
    import riscv_core_mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 64,
    parameter int CORE_DATA_WIDTH = 64,
    parameter int AXI_DATA_WIDTH  = 256,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int TIMEOUT_WIDTH   = 11
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_ic_read_req,
    input  logic [ADDR_WIDTH-1:0]      i_ic_read_address,
    output logic                       o_ic_read_done,
    output logic [AXI_DATA_WIDTH-1:0]  o_ic_block,
    input  logic                       i_dc_read_req,
    input  logic [ADDR_WIDTH-1:0]      i_dc_read_address,
    output logic                       o_dc_read_done,
    output logic [AXI_DATA_WIDTH-1:0]  o_dc_block,
    input  logic                       i_dc_write_valid,
    input  logic [ADDR_WIDTH-1:0]      i_dc_write_address,
    input  logic [CORE_DATA_WIDTH-1:0] i_dc_write_data,
    input  logic [7:0]                 i_dc_write_strobe,
    output logic                       o_dc_write_done,
    output logic                       o_bus_error,
    output logic                       o_mem_read_req,
    output logic [ADDR_WIDTH-1:0]      o_mem_read_address,
    input  logic                       i_mem_read_done,
    input  logic [AXI_DATA_WIDTH-1:0]  i_mem_read_data,
    output logic                       o_mem_write_valid,
    output logic [ADDR_WIDTH-1:0]      o_mem_write_address,
    output logic [CORE_DATA_WIDTH-1:0] o_mem_write_data,
    output logic [7:0]                 o_mem_write_strobe,
    input  logic                       i_mem_write_done
);

    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST =
        TIMEOUT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    arb_state_t               state;
    owner_t                   owner;
    logic [TIMEOUT_WIDTH-1:0] wd_count;

    logic [2:0] req_vec;
    logic [2:0] grant;
    owner_t     grant_id;
    logic       grant_valid;
    logic       grant_en;

    logic       busy;
    logic       done_in;
    logic       timeout_hit;
    logic       finish;

    assign req_vec  = {i_dc_write_valid, i_dc_read_req, i_ic_read_req};
    assign grant_en = (state == IDLE);

    riscv_core_rr_arbiter3 u_rr (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_req         (req_vec),
        .i_grant_en    (grant_en),
        .o_grant       (grant),
        .o_grant_id    (grant_id),
        .o_grant_valid (grant_valid)
    );

    // Completion sources: a downstream done matching the busy direction, or the watchdog
    always_comb begin
        busy        = (state != IDLE);
        done_in     = ((state == RD_BUSY) && i_mem_read_done) ||
                      ((state == WR_BUSY) && i_mem_write_done);
        timeout_hit = TIMEOUT_EN && busy && (wd_count == TIMEOUT_LAST);
        finish      = done_in || timeout_hit;
    end

    // Done pulses are routed only to the current owner; a real done masks the error
    always_comb begin
        o_ic_read_done  = (state == RD_BUSY) && (owner == IC_RD) && finish;
        o_dc_read_done  = (state == RD_BUSY) && (owner == DC_RD) && finish;
        o_dc_write_done = (state == WR_BUSY) && (owner == DC_WR) && finish;
        o_bus_error     = timeout_hit && !done_in;
    end

    // Refill data is passed straight through; consumers qualify it with their done
    assign o_ic_block = i_mem_read_data;
    assign o_dc_block = i_mem_read_data;

    // Transaction sequencer: latch winner payload, hold downstream request, retire on done/timeout
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state               <= IDLE;
            owner               <= IC_RD;
            wd_count            <= '0;
            o_mem_read_req      <= 1'b0;
            o_mem_read_address  <= '0;
            o_mem_write_valid   <= 1'b0;
            o_mem_write_address <= '0;
            o_mem_write_data    <= '0;
            o_mem_write_strobe  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner    <= grant_id;
                        wd_count <= '0;
                        if (grant[DC_WR]) begin
                            state               <= WR_BUSY;
                            o_mem_write_valid   <= 1'b1;
                            o_mem_write_address <= i_dc_write_address;
                            o_mem_write_data    <= i_dc_write_data;
                            o_mem_write_strobe  <= i_dc_write_strobe;
                        end else begin
                            state              <= RD_BUSY;
                            o_mem_read_req     <= 1'b1;
                            o_mem_read_address <= grant[IC_RD] ? i_ic_read_address
                                                               : i_dc_read_address;
                        end
                    end
                end
                RD_BUSY: begin
                    if (finish) begin
                        state          <= IDLE;
                        o_mem_read_req <= 1'b0;
                    end else begin
                        wd_count <= wd_count + 1'b1;
                    end
                end
                WR_BUSY: begin
                    if (finish) begin
                        state             <= IDLE;
                        o_mem_write_valid <= 1'b0;
                    end else begin
                        wd_count <= wd_count + 1'b1;
                    end
                end
                default: begin
                    state             <= IDLE;
                    o_mem_read_req    <= 1'b0;
                    o_mem_write_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
